tdc_uart_tx: RTL
================

// Module: tdc_uart_tx
// PURPOSE
//  Read-out end of the delay-line TDC. Snapshots the TDC stage_delays vector on request.
//  Encodes the thermometer code into a 7-bit stage count plus a bubble flag.
//  Serialises the result as one 8N1 UART byte on tx, for host-side capture of measurements.
// PARAMETERS
//  NUM_STAGES    10   width of stage_delays; legal range 1..127
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
// PORTS
//  clk           in   1           system clock, all logic on posedge
//  reset         in   1           synchronous, active-high
//  stage_delays  in   NUM_STAGES  TDC thermometer vector, bit0 = first stage
//  sample_valid  in   1           request: capture stage_delays and transmit one byte
//  sample_ready  out  1           high in IDLE only; transfer occurs when valid && ready
//  tx            out  1           UART serial out, idle high, LSB first
//  busy          out  1           high from accept until end of stop bit
//  last_code     out  8           byte of the most recently accepted sample
//  overrun       out  1           sticky; set when sample_valid && !sample_ready
// BEHAVIOUR
//  Reset values:
//   - tx = 1, busy = 0, sample_ready = 1, last_code = 8'h00, overrun = 0.
//   - FSM = IDLE; baud counter and bit index = 0.
//  Encoding (combinational on stage_delays, registered at accept):
//   - count = popcount(stage_delays), zero-extended to 7 bits.
//   - bubble = 1 unless stage_delays == (2**count)-1, i.e. the ones are contiguous from bit0.
//   - byte = {bubble, count[6:0]}.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: sample_ready = 1, tx = 1.
//     On valid && ready, at that edge: latch byte into shift reg and last_code;
//     enter START; load baud counter with CLKS_PER_BIT-1.
//   - START: tx = 0 for CLKS_PER_BIT cycles. tx falls on the first cycle after the accept edge.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7, shift right.
//   - STOP: tx = 1 for CLKS_PER_BIT cycles, then IDLE. No inter-frame gap beyond the stop bit.
//  Timing:
//   - Frame = exactly 10*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
//   - busy = (state != IDLE); sample_ready = !busy.
//  Baud counter:
//   - Counts down; advances the bit when it reaches 0, then reloads to CLKS_PER_BIT-1.
//   - Width $clog2(CLKS_PER_BIT).
//  Handshake and boundary conditions:
//   - sample_valid while busy: the sample is dropped, overrun is set, the frame is not disturbed.
//   - Simultaneous last STOP cycle and valid: not accepted (ready still 0), overrun is set.
//     It is accepted on the next cycle if still held.
//   - sample_valid held high continuously: back-to-back frames, one per 10*CLKS_PER_BIT+1 cycles.
//   - stage_delays may change at any time; only the value at the accept edge matters.
//   - All zeros encodes to 8'h00; all ones (NUM_STAGES=10) encodes to 8'h0A.
//   - Reset mid-frame: tx = 1 on the next edge; FSM goes to IDLE; overrun and last_code cleared.
//  No other state persists across reset.
// STRUCTURE
//  tdc_pkg (shared):
//   - typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tdc_tx_state_t;
//   - localparam UART_DATA_BITS = 8; localparam TDC_CODE_W = 7.
//  Sub-module tdc_therm_enc #(NUM_STAGES):
//   - Purely combinational: stage_delays -> count[6:0], bubble.
//   - Reusable by other TDC consumers.
//  Top level: FSM, baud counter, bit index, shift register, overrun flag.
// TESTING  (bench uses CLKS_PER_BIT=4, NUM_STAGES=10)
//  1. Reset, then idle 20 cycles -> tx=1, busy=0, sample_ready=1, last_code=00, overrun=0.
//  2. stage_delays=10'b0000011111, pulse valid -> last_code=8'h05.
//     tx = 0 | 1,0,1,0,0,0,0,0 | 1, each bit 4 cycles; busy for 40 cycles.
//  3. stage_delays=10'b0000010111 -> byte 8'h84 (count 4, bubble 1).
//     stage_delays=10'h3FF -> 8'h0A. stage_delays=0 -> 8'h00.
//  4. valid pulsed at cycle 10 of a frame -> frame bits unchanged, overrun=1 stays set;
//     no second frame follows.
//  5. valid held high 3 frames -> exactly 3 frames, 41-cycle period.
//     stage_delays changed mid-frame does not alter the frame in progress.
//  6. reset asserted during DATA bit 3 -> next cycle tx=1, busy=0, last_code=00.
//     The following request transmits a clean full frame.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC read-out path: transmitter states,
// UART frame geometry and the width of the encoded stage count.
package tdc_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tdc_tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int TDC_CODE_W     = 7;

  // The transmitted byte puts the bubble flag in the MSB so a host can spot
  // a corrupted thermometer code without decoding the count first.
  function automatic logic [UART_DATA_BITS-1:0] pack_code(
    input logic                  bubble,
    input logic [TDC_CODE_W-1:0] count
  );
    return {bubble, count};
  endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// Thermometer-code encoder for the delay-line TDC.
// Purely combinational: counts the set stages and flags any code whose ones
// are not a contiguous run starting at bit 0 (a "bubble").
module tdc_therm_enc
  import tdc_pkg::*;
#(
  parameter int NUM_STAGES = 10
) (
  input  logic [NUM_STAGES-1:0] stage_delays,
  output logic [TDC_CODE_W-1:0] count,
  output logic                  bubble
);

  logic [TDC_CODE_W-1:0] ones;
  logic [NUM_STAGES-1:0] ideal;

  // Population count of the raw vector; NUM_STAGES <= 127 so it always fits.
  always_comb begin
    ones = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      ones = ones + TDC_CODE_W'(stage_delays[i]);
    end
  end

  // Rebuild the clean thermometer code with the same number of ones; any
  // difference from the input means the ones were not packed from bit 0.
  always_comb begin
    ideal = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      ideal[i] = (TDC_CODE_W'(i) < ones);
    end
  end

  assign count  = ones;
  assign bubble = (stage_delays != ideal);

endmodule

// File: rtl/tdc_uart_tx.sv
// Read-out end of the delay-line TDC. On an accepted request the encoded
// stage count is captured and shifted out as a single 8N1 UART byte.
// Requests that arrive while a frame is in flight are dropped and recorded
// in a sticky overrun flag.
module tdc_uart_tx
  import tdc_pkg::*;
#(
  parameter int NUM_STAGES   = 10,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_STAGES-1:0]     stage_delays,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      tx,
  output logic                      busy,
  output logic [UART_DATA_BITS-1:0] last_code,
  output logic                      overrun
);

  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

  tdc_tx_state_t             state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic [UART_DATA_BITS-1:0] last_code_q;
  logic                      overrun_q;

  logic [TDC_CODE_W-1:0]     enc_count;
  logic                      enc_bubble;
  logic [UART_DATA_BITS-1:0] enc_byte;
  logic                      idle;
  logic                      accept;
  logic                      baud_done;

  tdc_therm_enc #(
    .NUM_STAGES (NUM_STAGES)
  ) u_enc (
    .stage_delays (stage_delays),
    .count        (enc_count),
    .bubble       (enc_bubble)
  );

  assign enc_byte  = pack_code(enc_bubble, enc_count);
  assign idle      = (state_q == TX_IDLE);
  assign accept    = sample_valid && idle;
  assign baud_done = (baud_q == '0);

  // Frame sequencing: each non-idle state lasts one full baud period, timed
  // by a down-counter that is reloaded whenever it expires.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d   = TX_START;
          baud_d    = BAUD_RELOAD;
          bit_idx_d = '0;
          shift_d   = enc_byte;
        end
      end
      TX_START: begin
        if (baud_done) begin
          state_d   = TX_DATA;
          baud_d    = BAUD_RELOAD;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          state_d = TX_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level for the coming cycle, decoded from the next state so the
  // serial output comes straight from a flop and cannot glitch.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Transmitter state, baud timing, shift register and serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Host-visible status: the byte of the last accepted sample, and a sticky
  // flag for any request that had to be dropped because we were busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_code_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept) begin
        last_code_q <= enc_byte;
      end
      if (sample_valid && !idle) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign sample_ready = idle;
  assign busy         = !idle;
  assign tx           = tx_q;
  assign last_code    = last_code_q;
  assign overrun      = overrun_q;

endmodule
